// File: rtl/buffer.sv
// Circular sample buffer: one din sample stored per clk edge, with running
// max/min over valid entries, next write index and random-access read.
module buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [7:0]       rd_addr,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] min,
    output logic [7:0]       wr_addr,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    wptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
            wptr  <= '0;
        end else begin
            mem[wptr]   <= din;
            valid[wptr] <= 1'b1;
            wptr        <= wptr + AW'(1);
        end
    end

    // Reductions only see written slots, so an empty ring yields max=0, min=all-ones.
    always_comb begin
        max = '0;
        min = '1;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (mem[i] > max) max = mem[i];
                if (mem[i] < min) min = mem[i];
            end
        end
    end

    assign dout    = mem[rd_addr[AW-1:0]];
    assign wr_addr = 8'(wptr);

    // Upper read-address bits alias modulo DEPTH and are intentionally ignored.
    generate
        if (AW < 8) begin : g_rd_alias
            logic unused_rd_bits;
            assign unused_rd_bits = ^rd_addr[7:AW];
        end
    endgenerate

endmodule

// File: tb/tb_buffer.sv
// Randomized bench for buffer: every clk edge is a write or a reset, checked
// against a history-queue reference model of the ring.
module tb_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic [7:0]       rd_addr;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [7:0]       wr_addr;
    logic [WIDTH-1:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: newest DEPTH samples since reset, plus total writes since reset.
    logic [WIDTH-1:0] exp_q[$];
    int               n_wr = 0;

    buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .rd_addr (rd_addr),
        .max     (max),
        .min     (min),
        .wr_addr (wr_addr),
        .dout    (dout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model queries
    function automatic logic [WIDTH-1:0] exp_entry(input int a);
        logic [WIDTH-1:0] r = '0;
        int base = n_wr - exp_q.size();
        for (int k = base; k < n_wr; k++) begin
            if (k % DEPTH == a) r = exp_q[k - base];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_max();
        logic [WIDTH-1:0] r = '0;
        foreach (exp_q[i]) if (exp_q[i] > r) r = exp_q[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_min();
        logic [WIDTH-1:0] r = '1;
        foreach (exp_q[i]) if (exp_q[i] < r) r = exp_q[i];
        return r;
    endfunction

    // driver tasks: each consumes exactly one clk edge
    task automatic do_write(input logic [WIDTH-1:0] v);
        din   = v;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(v);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        n_wr++;
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] junk);
        din   = junk;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        n_wr = 0;
    endtask

    task automatic check_state();
        check("wr_addr", 32'(wr_addr), 32'(n_wr % DEPTH));
        check("max", 32'(max), 32'(exp_max()));
        check("min", 32'(min), 32'(exp_min()));
        rd_addr = 8'($urandom_range(0, 255));
        #1;
        check("dout_rand", 32'(dout), 32'(exp_entry(int'(rd_addr) % DEPTH)));
    endtask

    task automatic sweep_dout();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a + DEPTH * $urandom_range(0, 15));
            #1;
            check("dout_sweep", 32'(dout), 32'(exp_entry(a)));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] fill_vals [5] = '{8'd10, 8'd30, 8'd20, 8'd5, 8'd25};
        reset   = 1'b1;
        din     = 8'hA5;
        rd_addr = 8'h00;

        // reset state
        do_reset(8'h5A);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_max", 32'(max), 32'h00);
        check("rst_min", 32'(min), 32'hFF);
        sweep_dout();

        // fill
        foreach (fill_vals[i]) do_write(fill_vals[i]);
        check("fill_wr_addr", 32'(wr_addr), 32'd5);
        check("fill_max", 32'(max), 32'd30);
        check("fill_min", 32'(min), 32'd5);
        rd_addr = 8'd1; #1; check("fill_dout1", 32'(dout), 32'd30);
        rd_addr = 8'd7; #1; check("fill_dout7", 32'(dout), 32'd0);
        rd_addr = 8'h13; #1; check("alias_dout", 32'(dout), 32'd5);
        sweep_dout();

        // mid-fill reset discards history and ignores din
        do_reset(8'd99);
        check("mrst_wr_addr", 32'(wr_addr), 32'h0);
        check("mrst_max", 32'(max), 32'h00);
        check("mrst_min", 32'(min), 32'hFF);
        sweep_dout();

        // wrap
        for (int i = 0; i < DEPTH; i++) do_write(8'd100);
        check("full_wr_addr", 32'(wr_addr), 32'd0);
        do_write(8'd50);
        check("wrap_wr_addr", 32'(wr_addr), 32'd1);
        rd_addr = 8'd0; #1; check("wrap_dout0", 32'(dout), 32'd50);
        check("wrap_max", 32'(max), 32'd100);
        check("wrap_min", 32'(min), 32'd50);
        sweep_dout();

        // overwrite extreme
        do_reset(8'd7);
        do_write(8'd200);
        for (int i = 0; i < DEPTH - 1; i++) do_write(8'd10);
        check("ovw_max_before", 32'(max), 32'd200);
        do_write(8'd10);
        check("ovw_max_after", 32'(max), 32'd10);
        check("ovw_min_after", 32'(min), 32'd10);
        check("ovw_wr_addr", 32'(wr_addr), 32'd1);
        check_state();

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset(8'($urandom));
            else if ($urandom_range(0, 3) == 0) do_write(8'($urandom_range(0, 1) * 255));
            else do_write(8'($urandom));
            check_state();
            if (n % 64 == 0) sweep_dout();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
